// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial add controller. A single full-adder cell is stepped over WIDTH
// clock cycles to add two WIDTH-bit operands LSB-first. This trades
// throughput for area in the microprocessor datapath. A start/busy/done
// handshake sequences each operation.
//
// Build option:
//   SERIAL_SUB_EN - when defined, adds the Sub input. Sub=1 at an accepted
//                   start computes A-B as A + ~B + 1, and Cin is ignored.
//                   Cout=1 then means "no borrow".
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous reset, active low
//   start  in   1      request; sampled only in IDLE or DONE
//   A      in   WIDTH  operand A, captured on an accepted start
//   B      in   WIDTH  operand B, captured on an accepted start
//   Cin    in   1      carry-in, captured on an accepted start
//   Sub    in   1      (SERIAL_SUB_EN only) 1 = compute A-B
//   busy   out  1      high while the operation runs
//   done   out  1      one-cycle pulse; Sum/Cout are valid
//   Sum    out  WIDTH  result; held until the next accepted start
//   Cout   out  1      carry out of bit WIDTH-1; held with Sum
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // The encoding is chosen so that busy and done are each a single state
  // flop. This keeps both outputs glitch-free without extra registers.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_count;

  logic             w_faSum;
  logic             w_faCout;
  logic             w_last;
  logic [WIDTH-1:0] w_opBLoad;
  logic             w_carryLoad;

  // This is the single full-adder cell. It works on the current LSBs and the
  // running carry.
  assign w_faSum  = r_opA[0] ^ r_opB[0] ^ r_carry;
  assign w_faCout = (r_opA[0] & r_opB[0]) | (r_carry & (r_opA[0] ^ r_opB[0]));

  assign w_last = (r_count == CW'(WIDTH - 1));

  // Subtraction reuses the adder as A + ~B + 1. The carry-in is forced to 1.
`ifdef SERIAL_SUB_EN
  assign w_opBLoad   = Sub ? ~B : B;
  assign w_carryLoad = Sub ? 1'b1 : Cin;
`else
  assign w_opBLoad   = B;
  assign w_carryLoad = Cin;
`endif

  // Control and datapath sequencing.
  // Partial sum bits collect in r_acc. They are shifted in at the MSB so that
  // after WIDTH steps bit 0 has reached the bottom. The visible Sum register
  // is written only on the last step, so it reads 0 between accept and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_opA   <= '0;
      r_opB   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_opA   <= A;
            r_opB   <= w_opBLoad;
            r_carry <= w_carryLoad;
            r_count <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc   <= {w_faSum, r_acc[WIDTH-1:1]};
          r_carry <= w_faCout;
          r_opA   <= {1'b0, r_opA[WIDTH-1:1]};
          r_opB   <= {1'b0, r_opB[WIDTH-1:1]};
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_sum   <= {w_faSum, r_acc[WIDTH-1:1]};
            r_cout  <= w_faCout;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_state[0];
  assign done = r_state[1];
  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl (WIDTH=8). The stimulus pushes the
// hand-computed {Cout,Sum} of each operation into a queue. A monitor pops the
// queue and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Cin = 1'b0;
  logic             Sub = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  int testsRun    = 0;
  int testsFailed = 0;
  int doneCount   = 0;
  int opsIssued   = 0;

  logic [8:0] expQ[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [8:0] exp;
  } vec_t;

  vec_t addVecs[9];
  vec_t subVecs[4];

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
`ifdef SERIAL_SUB_EN
    .Sub   (Sub),
`endif
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Global time limit, so a stuck design cannot hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor. It samples on the falling edge, away from the active
  // clock edge.
  always @(negedge clk) begin : monitorBlk
    logic [8:0] e;
    if (rst_n && done) begin
      doneCount++;
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected done: got {Cout,Sum}=%0h, expected no pulse",
                 {Cout, Sum});
      end else begin
        e = expQ.pop_front();
        checkOutput("result", 32'({Cout, Sum}), 32'(e));
      end
    end
  end

  // The caller is on a falling edge. The request is sampled at the next
  // rising edge.
  task automatic issueOp(input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input logic [8:0] exp);
    A     = a;
    B     = b;
    Cin   = cin;
    Sub   = sub;
    start = 1'b1;
    expQ.push_back(exp);
    opsIssued++;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " done seen"}, 32'(done), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    issueOp(v.a, v.b, v.cin, v.sub, v.exp);
    @(negedge clk);
    start = 1'b0;
    waitDone("vector");
  endtask

  initial begin : mainBlk
    logic sawDone;

    addVecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 9'h100};
    addVecs[1] = '{8'hFF, 8'h00, 1'b1, 1'b0, 9'h100};
    addVecs[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 9'h000};
    addVecs[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 9'h100};
    addVecs[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 9'h080};
    addVecs[5] = '{8'h7F, 8'h80, 1'b1, 1'b0, 9'h100};
    addVecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF};
    addVecs[7] = '{8'hA5, 8'h5A, 1'b0, 1'b0, 9'h0FF};
    addVecs[8] = '{8'h01, 8'h01, 1'b1, 1'b0, 9'h003};

    subVecs[0] = '{8'h10, 8'h01, 1'b0, 1'b1, 9'h10F};
    subVecs[1] = '{8'h01, 8'h02, 1'b0, 1'b1, 9'h0FF};
    subVecs[2] = '{8'h05, 8'h03, 1'b0, 1'b1, 9'h102};
    subVecs[3] = '{8'h05, 8'h03, 1'b1, 1'b1, 9'h102};

    // Check the reset state.
    #2;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset Sum",  32'(Sum),  32'd0);
    checkOutput("reset Cout", 32'(Cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Cycle-accurate timing of one operation: 5A + 3C = 96.
    issueOp(8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t1 busy run%0d", i), 32'(busy), 32'd1);
      checkOutput($sformatf("t1 done run%0d", i), 32'(done), 32'd0);
      checkOutput($sformatf("t1 Sum run%0d", i),  32'(Sum),  32'd0);
      @(negedge clk);
    end
    checkOutput("t1 done pulse", 32'(done), 32'd1);
    checkOutput("t1 busy at done", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t1 done cleared", 32'(done), 32'd0);
    checkOutput("t1 busy idle", 32'(busy), 32'd0);
    checkOutput("t1 Sum held", 32'(Sum), 32'h96);
    checkOutput("t1 Cout held", 32'(Cout), 32'd0);

    // Corner vectors, issued back-to-back in each DONE cycle.
    foreach (addVecs[i]) applyStimulus(addVecs[i]);
    @(negedge clk);
    @(negedge clk);

    // Start is held high while new operands are driven mid-run. The second
    // accept happens in the DONE cycle, with whatever operands are present.
    issueOp(8'h11, 8'h22, 1'b0, 1'b0, 9'h033);
    @(negedge clk);
    A   = 8'hFF;
    B   = 8'hFF;
    Cin = 1'b1;
    expQ.push_back(9'h1FF);
    opsIssued++;
    waitDone("t3 first");
    @(negedge clk);
    checkOutput("t3 busy after b2b", 32'(busy), 32'd1);
    start = 1'b0;
    waitDone("t3 second");
    @(negedge clk);
    checkOutput("t3 Sum held", 32'(Sum), 32'hFF);
    checkOutput("t3 Cout held", 32'(Cout), 32'd1);

    // Abort mid-run with reset. The aborted operation has no expected entry.
    A     = 8'h01;
    B     = 8'h02;
    Cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t4 abort busy", 32'(busy), 32'd0);
    checkOutput("t4 abort done", 32'(done), 32'd0);
    checkOutput("t4 abort Sum",  32'(Sum),  32'd0);
    checkOutput("t4 abort Cout", 32'(Cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("t4 no done after abort", 32'(sawDone), 32'd0);
    applyStimulus('{8'h12, 8'h34, 1'b0, 1'b0, 9'h046});

`ifdef SERIAL_SUB_EN
    // Subtraction, including Sub=1 with Cin=0.
    foreach (subVecs[i]) applyStimulus(subVecs[i]);
`endif

    repeat (3) @(negedge clk);
    checkOutput("done count", 32'(doneCount), 32'(opsIssued));
    checkOutput("queue empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
